// File: rtl/seq_entry_display.sv
// seq_entry_display
//   Latches a target sequence of NUM_DIGITS symbols, shows it on seven-segment
//   digits for SHOW_SECS one_sec ticks, then blanks the target and lets the
//   player re-enter it with move/next buttons. A decimal-point cursor marks the
//   digit being edited. On completion the entry is compared against the target.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   start        one-cycle pulse: latch sequence_in and begin the show phase
//   sequence_in  target sequence, digit i = [i*SYM_W +: SYM_W]
//   one_sec      one-cycle tick per second
//   button_move  one-cycle pulse: cycle the symbol under the cursor
//   button_next  one-cycle pulse: advance the cursor / finish entry
//   sequence_out current entered sequence, same packing as sequence_in
//   sevseg       digit i = [i*8 +: 8]; [6:0] segments, [7] DP (active-low)
//   busy         high while showing or entering
//   done         one-cycle pulse when an entry completes
//   match        result of the last completed entry, held until next start
module seq_entry_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int SYM_W       = 2,
    parameter int NUM_SYMBOLS = 4,
    parameter int SHOW_SECS   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_DIGITS*SYM_W-1:0]   sequence_in,
    input  logic                          one_sec,
    input  logic                          button_move,
    input  logic                          button_next,
    output logic [NUM_DIGITS*SYM_W-1:0]   sequence_out,
    output logic [NUM_DIGITS*8-1:0]       sevseg,
    output logic                          busy,
    output logic                          done,
    output logic                          match
);

    localparam int SEQ_W = NUM_DIGITS * SYM_W;
    localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_ENTRY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SEQ_W-1:0]   target_q, target_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [CUR_W-1:0]   cursor_q, cursor_d;
    logic [3:0]         sec_q, sec_d;
    logic               match_q, match_d;
    logic               show_final_q, show_final_d;
    logic               busy_q, done_q;

    // Segment pattern for a symbol index; out-of-range indices show an error glyph.
    function automatic logic [6:0] seg_glyph(input logic [SYM_W-1:0] sym);
        logic [6:0] g;
        if (int'(sym) >= NUM_SYMBOLS) begin
            g = 7'b0100001;
        end else begin
            case (int'(sym))
                0:       g = 7'b1111110;
                1:       g = 7'b1111001;
                2:       g = 7'b1110111;
                3:       g = 7'b1001111;
                4:       g = 7'b0110000;
                5:       g = 7'b0001110;
                6:       g = 7'b1000001;
                7:       g = 7'b0111111;
                default: g = 7'b0100001;
            endcase
        end
        return g;
    endfunction

    // Cycle a symbol through 0..NUM_SYMBOLS-1 with wrap.
    function automatic logic [SYM_W-1:0] next_sym(input logic [SYM_W-1:0] sym);
        logic [SYM_W-1:0] r;
        if (int'(sym) >= NUM_SYMBOLS - 1) r = '0;
        else                              r = sym + SYM_W'(1);
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        seq_d        = seq_q;
        cursor_d     = cursor_q;
        sec_d        = sec_q;
        match_d      = match_q;
        show_final_d = show_final_q;

        case (state_q)
            S_IDLE: begin
                // A tick arriving with start is not counted: sec is cleared here.
                if (start) begin
                    target_d     = sequence_in;
                    sec_d        = '0;
                    match_d      = 1'b0;
                    show_final_d = 1'b0;
                    state_d      = S_SHOW;
                end
            end
            S_SHOW: begin
                if (sec_q == 4'(SHOW_SECS)) begin
                    seq_d    = '0;
                    cursor_d = '0;
                    state_d  = S_ENTRY;
                end else if (one_sec) begin
                    sec_d = sec_q + 4'd1;
                end
            end
            S_ENTRY: begin
                // next has priority; a simultaneous move is dropped.
                if (button_next) begin
                    if (cursor_q == CUR_W'(NUM_DIGITS - 1)) state_d = S_DONE;
                    else                                   cursor_d = cursor_q + CUR_W'(1);
                end else if (button_move) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (cursor_q == CUR_W'(i))
                            seq_d[i*SYM_W +: SYM_W] = next_sym(seq_q[i*SYM_W +: SYM_W]);
                    end
                end
            end
            S_DONE: begin
                match_d      = (seq_q == target_q);
                show_final_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            seq_q        <= '0;
            cursor_q     <= '0;
            sec_q        <= '0;
            match_q      <= 1'b0;
            show_final_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            seq_q        <= seq_d;
            cursor_q     <= cursor_d;
            sec_q        <= sec_d;
            match_q      <= match_d;
            show_final_q <= show_final_d;
            busy_q       <= (state_d == S_SHOW) || (state_d == S_ENTRY);
            done_q       <= (state_d == S_DONE);
        end
    end

    // Display decode from registered state: target in SHOW, entry with cursor
    // DP in ENTRY, final entry (DP off) after a completed entry, else blank.
    always_comb begin
        sevseg = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state_q == S_SHOW)
                sevseg[i*8 +: 8] = {1'b1, seg_glyph(target_q[i*SYM_W +: SYM_W])};
            else if (state_q == S_ENTRY)
                sevseg[i*8 +: 8] = {(cursor_q != CUR_W'(i)), seg_glyph(seq_q[i*SYM_W +: SYM_W])};
            else if (state_q == S_DONE || show_final_q)
                sevseg[i*8 +: 8] = {1'b1, seg_glyph(seq_q[i*SYM_W +: SYM_W])};
        end
    end

    assign sequence_out = seq_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign match        = match_q;

endmodule

// File: tb/tb_seq_entry_display.sv
// Testbench for seq_entry_display: instance A uses the default parameters,
// instance B uses NUM_DIGITS=6, SYM_W=3, NUM_SYMBOLS=8, SHOW_SECS=3.
// Completed entries are predicted into per-instance queues and checked on done.
module tb_seq_entry_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        one_sec = 1'b0;
    logic        button_move = 1'b0;
    logic        button_next = 1'b0;

    logic        start_a = 1'b0;
    logic [7:0]  seq_in_a = '0;
    logic [7:0]  seq_out_a;
    logic [31:0] sevseg_a;
    logic        busy_a, done_a, match_a;

    logic        start_b = 1'b0;
    logic [17:0] seq_in_b = '0;
    logic [17:0] seq_out_b;
    logic [47:0] sevseg_b;
    logic        busy_b, done_b, match_b;

    always #5 clk = ~clk;

    seq_entry_display #(.NUM_DIGITS(4), .SYM_W(2), .NUM_SYMBOLS(4), .SHOW_SECS(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sequence_in(seq_in_a),
        .one_sec(one_sec), .button_move(button_move), .button_next(button_next),
        .sequence_out(seq_out_a), .sevseg(sevseg_a), .busy(busy_a),
        .done(done_a), .match(match_a)
    );

    seq_entry_display #(.NUM_DIGITS(6), .SYM_W(3), .NUM_SYMBOLS(8), .SHOW_SECS(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sequence_in(seq_in_b),
        .one_sec(one_sec), .button_move(button_move), .button_next(button_next),
        .sequence_out(seq_out_b), .sevseg(sevseg_b), .busy(busy_b),
        .done(done_b), .match(match_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [23:0] seq;
        logic        m;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    // Reference model of the instance under test
    int          m_inst;
    int          m_nd, m_ns, m_sw, m_secs;
    logic [23:0] m_tgt;
    int          m_sym[8];
    int          m_cur;
    logic [63:0] show_snap;

    function automatic logic [6:0] seg_ref(input int s, input int ns);
        logic [6:0] g;
        if (s >= ns) g = 7'b0100001;
        else begin
            case (s)
                0: g = 7'b1111110;
                1: g = 7'b1111001;
                2: g = 7'b1110111;
                3: g = 7'b1001111;
                4: g = 7'b0110000;
                5: g = 7'b0001110;
                6: g = 7'b1000001;
                default: g = 7'b0111111;
            endcase
        end
        return g;
    endfunction

    function automatic int tgt_digit(input int i);
        logic [23:0] v;
        v = (m_tgt >> (i * m_sw)) & ((24'd1 << m_sw) - 24'd1);
        return int'(v);
    endfunction

    function automatic logic [23:0] pack_model();
        logic [23:0] v = '0;
        for (int i = 0; i < m_nd; i++) v = v | (24'(m_sym[i]) << (i * m_sw));
        return v;
    endfunction

    // mode: 0 blank, 1 target, 2 entry with cursor, 3 final entry
    task automatic check_disp(input string tag, input int mode);
        logic [63:0] exp = '1;
        logic [63:0] obs;
        int          s;
        for (int i = 0; i < m_nd; i++) begin
            s = (mode == 1) ? tgt_digit(i) : m_sym[i];
            if (mode != 0) exp[i*8 +: 8] = {!(mode == 2 && i == m_cur), seg_ref(s, m_ns)};
        end
        obs = (m_inst == 0) ? {32'hFFFF_FFFF, sevseg_a} : {16'hFFFF, sevseg_b};
        chk(tag, obs, exp);
    endtask

    task automatic press(input logic mv, input logic nx);
        exp_t e;
        @(posedge clk); #1;
        button_move = mv;
        button_next = nx;
        if (nx) begin
            if (m_cur == m_nd - 1) begin
                e.seq = pack_model();
                e.m   = (e.seq == m_tgt);
                if (m_inst == 0) sb_a.push_back(e); else sb_b.push_back(e);
            end else m_cur++;
        end else if (mv) begin
            m_sym[m_cur] = (m_sym[m_cur] + 1) % m_ns;
        end
        @(posedge clk); #1;
        button_move = 1'b0;
        button_next = 1'b0;
    endtask

    task automatic enter_seq(input int from, input int to);
        for (int i = from; i < to; i++) begin
            repeat (tgt_digit(i)) press(1'b1, 1'b0);
            press(1'b0, 1'b1);
        end
    endtask

    task automatic set_start(input logic v, input logic [23:0] s);
        if (m_inst == 0) begin start_a = v; seq_in_a = s[7:0]; end
        else             begin start_b = v; seq_in_b = s[17:0]; end
    endtask

    task automatic show_phase(input int inst, input logic [23:0] tgt,
                              input bit coincide, input bit try_restart);
        m_inst = inst;
        m_nd   = (inst == 0) ? 4 : 6;
        m_sw   = (inst == 0) ? 2 : 3;
        m_ns   = (inst == 0) ? 4 : 8;
        m_secs = (inst == 0) ? 2 : 3;
        m_tgt  = tgt;
        m_cur  = 0;
        for (int i = 0; i < 8; i++) m_sym[i] = 0;

        @(posedge clk); #1;
        set_start(1'b1, tgt);
        one_sec = coincide;
        @(posedge clk); #1;
        set_start(1'b0, tgt);
        one_sec = 1'b0;
        @(negedge clk);
        chk("show_busy", (inst == 0) ? busy_a : busy_b, 1'b1);
        check_disp("show_disp", 1);
        show_snap = (inst == 0) ? {32'hFFFF_FFFF, sevseg_a} : {16'hFFFF, sevseg_b};

        for (int k = 0; k < m_secs; k++) begin
            if (try_restart && k == 1) begin
                @(posedge clk); #1;
                set_start(1'b1, ~tgt);
                @(posedge clk); #1;
                set_start(1'b0, tgt);
            end
            @(posedge clk); #1;
            one_sec = 1'b1;
            @(posedge clk); #1;
            one_sec = 1'b0;
            if (k < m_secs - 1) begin
                @(posedge clk);
                @(negedge clk);
                check_disp("show_hold", 1);
            end
        end
        @(negedge clk);
        check_disp("show_last", 1);
        @(posedge clk);
        @(negedge clk);
        chk("entry_busy", (inst == 0) ? busy_a : busy_b, 1'b1);
        check_disp("entry_disp0", 2);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 64'(sb_a.size() + sb_b.size()), 64'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitors: pop on done, check match one cycle later.
    int   done_cnt_a = 0, done_cnt_b = 0;
    logic pend_a = 1'b0, pend_m_a = 1'b0;
    logic pend_b = 1'b0, pend_m_b = 1'b0;
    exp_t e_a, e_b;

    always @(negedge clk) begin
        if (pend_a) begin
            chk("a_match", match_a, pend_m_a);
            pend_a <= 1'b0;
        end
        if (done_a) begin
            done_cnt_a <= done_cnt_a + 1;
            if (sb_a.size() == 0) chk("a_done_unexpected", done_a, 1'b0);
            else begin
                e_a = sb_a.pop_front();
                chk("a_seq_at_done", seq_out_a, e_a.seq);
                pend_m_a <= e_a.m;
                pend_a   <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (pend_b) begin
            chk("b_match", match_b, pend_m_b);
            pend_b <= 1'b0;
        end
        if (done_b) begin
            done_cnt_b <= done_cnt_b + 1;
            if (sb_b.size() == 0) chk("b_done_unexpected", done_b, 1'b0);
            else begin
                e_b = sb_b.pop_front();
                chk("b_seq_at_done", seq_out_b, e_b.seq);
                pend_m_b <= e_b.m;
                pend_b   <= 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_match", match_a, 1'b0);
        chk("rst_seq", seq_out_a, 8'h00);
        chk("rst_sevseg_a", sevseg_a, 32'hFFFF_FFFF);
        chk("rst_sevseg_b", sevseg_b, 48'hFFFF_FFFF_FFFF);

        // Correct entry of 8'h1B (digits 3,2,1,0)
        show_phase(0, 24'h1B, 1'b0, 1'b0);
        chk("show_d0_raw", show_snap[7:0], 8'b1_1001111);
        chk("show_d3_raw", show_snap[31:24], 8'b1_1111110);
        chk("entry_first_disp", sevseg_a, 32'hFEFE_FE7E);
        enter_seq(0, 4);
        wait_drain();
        chk("ok_seq", seq_out_a, 8'h1B);
        chk("ok_match", match_a, 1'b1);
        chk("ok_busy", busy_a, 1'b0);
        m_cur = -1;
        check_disp("final_disp", 3);
        chk("ok_done_cnt", 64'(done_cnt_a), 64'd1);

        // Wrong entry; start carries a coincident tick that must not count
        show_phase(0, 24'h1B, 1'b1, 1'b0);
        repeat (4) press(1'b0, 1'b1);
        wait_drain();
        chk("bad_match", match_a, 1'b0);
        chk("bad_seq", seq_out_a, 8'h00);
        chk("bad_done_cnt", 64'(done_cnt_a), 64'd2);

        // Wrap, move+next collision, then reset mid-entry at cursor 2
        show_phase(0, 24'h1B, 1'b0, 1'b0);
        repeat (5) press(1'b1, 1'b0);
        chk("wrap_sym", seq_out_a[1:0], 2'd1);
        press(1'b1, 1'b1);
        chk("collide_seq", seq_out_a, 8'h01);
        @(negedge clk);
        check_disp("collide_disp", 2);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        @(negedge clk);
        check_disp("cur2_disp", 2);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_sevseg", sevseg_a, 32'hFFFF_FFFF);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_seq", seq_out_a, 8'h00);
        repeat (4) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt_a), 64'd2);

        // Normal operation after the abort
        show_phase(0, 24'hE4, 1'b0, 1'b0);
        enter_seq(0, 4);
        wait_drain();
        chk("restart_match", match_a, 1'b1);
        chk("restart_seq", seq_out_a, 8'hE4);

        // Wide instance: digits 7,0,5,2,6,1; start during SHOW is ignored
        show_phase(1, 24'd7 | (24'd5 << 6) | (24'd2 << 9) | (24'd6 << 12) | (24'd1 << 15),
                   1'b0, 1'b1);
        chk("b_sym7_raw", show_snap[6:0], 7'b0111111);
        enter_seq(0, 5);
        @(negedge clk);
        chk("b_busy_5next", busy_b, 1'b1);
        chk("b_no_early_done", 64'(done_cnt_b), 64'd0);
        enter_seq(5, 6);
        wait_drain();
        chk("b_match_final", match_b, 1'b1);
        chk("b_busy_end", busy_b, 1'b0);

        chk("a_done_total", 64'(done_cnt_a), 64'd3);
        chk("b_done_total", 64'(done_cnt_b), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
